sim_lifecycle_ctrl: RTL and testbench

SIM_LIFECYCLE_CTRL -- requirements
Module: sim_lifecycle_ctrl

---
 rtl/sim_lifecycle_ctrl.sv | 135 +++++++++++++
 tb/tb_sim_lifecycle_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_lifecycle_ctrl.sv
// Simulation lifecycle sequencer: DUT reset/init pulses, watchdog-driven quit/drain,
// timeouts, wave-dump window and a saturating cycle counter.
module sim_lifecycle_ctrl #(
  parameter int unsigned CYCLE_W            = 64,
  parameter int unsigned RESET_CYCLES       = 5,
  parameter int unsigned INIT_CYCLES        = 1,
  parameter int unsigned TIMEOUT_AFTER_QUIT = 10000,
  parameter int unsigned GLOBAL_TIMEOUT     = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               idle,
  input  logic               wd_valid,
  input  logic [7:0]         wd_status,
  input  logic [CYCLE_W-1:0] dump_start,
  input  logic [CYCLE_W-1:0] dump_end,
  output logic               dut_reset,
  output logic               initFlag,
  output logic               wd_poll,
  output logic               dump_en,
  output logic [CYCLE_W-1:0] cycle,
  output logic [CYCLE_W-1:0] quit_cycle,
  output logic               finish,
  output logic               fatal,
  output logic [1:0]         fatal_code
);

  typedef enum logic [2:0] {StBoot, StRun, StDrain, StDone, StFail} state_e;

  localparam logic [CYCLE_W-1:0] ResetCyc  = CYCLE_W'(RESET_CYCLES);
  localparam logic [CYCLE_W-1:0] InitCyc   = CYCLE_W'(INIT_CYCLES);
  localparam logic [CYCLE_W-1:0] GlobalCyc = CYCLE_W'(GLOBAL_TIMEOUT);
  localparam logic [CYCLE_W-1:0] CycOne    = CYCLE_W'(1);
  localparam logic [CYCLE_W:0]   DrainCyc  = (CYCLE_W+1)'(TIMEOUT_AFTER_QUIT);

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [CYCLE_W-1:0] quit_q, quit_d;
  logic [1:0]         code_q, code_d;
  logic               dump_q, dump_d;
  logic               dut_reset_q, init_q, wd_poll_q, finish_q, fatal_q;
  logic               counting;
  logic [CYCLE_W:0]   drain_limit;

  // Threshold checks use cycle_d, the count being loaded on this edge, so that
  // "on the edge where cycle reaches N" lines up with the registered outputs.
  always_comb begin
    state_d     = state_q;
    quit_d      = quit_q;
    code_d      = code_q;
    dump_d      = dump_q;
    counting    = (state_q == StBoot) || (state_q == StRun) || (state_q == StDrain);
    cycle_d     = cycle_q;
    drain_limit = {1'b0, quit_q} + DrainCyc;

    if (counting && (cycle_q != {CYCLE_W{1'b1}})) begin
      cycle_d = cycle_q + CycOne;
    end

    unique case (state_q)
      StBoot: begin
        if (cycle_d >= ResetCyc) state_d = StRun;
      end
      StRun: begin
        if (wd_valid) begin
          if (wd_status == 8'hff) begin
            quit_d  = cycle_q;
            state_d = idle ? StDone : StDrain;
          end else if (wd_status != 8'h00) begin
            state_d = StFail;
            code_d  = 2'd1;
          end
        end
      end
      StDrain: begin
        if (idle) begin
          state_d = StDone;
        end else if ({1'b0, cycle_d} > drain_limit) begin
          state_d = StFail;
          code_d  = 2'd2;
        end
      end
      default: ;
    endcase

    // Global timeout only applies if nothing else already ended the run.
    if (counting && (GLOBAL_TIMEOUT != 0) && (cycle_d == GlobalCyc) &&
        (state_d != StDone) && (state_d != StFail)) begin
      state_d = StFail;
      code_d  = 2'd3;
    end

    if (counting) begin
      if ((cycle_d == dump_start) || ((dump_start == '0) && (cycle_q == '0))) dump_d = 1'b1;
      if ((dump_end != '0) && (cycle_d == dump_end)) dump_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StBoot;
      cycle_q     <= '0;
      quit_q      <= '0;
      code_q      <= 2'd0;
      dump_q      <= 1'b0;
      dut_reset_q <= 1'b1;
      init_q      <= 1'b1;
      wd_poll_q   <= 1'b0;
      finish_q    <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      quit_q      <= quit_d;
      code_q      <= code_d;
      dump_q      <= dump_d;
      dut_reset_q <= (cycle_d < ResetCyc);
      init_q      <= (cycle_d < InitCyc);
      wd_poll_q   <= (state_d == StRun);
      finish_q    <= (state_d == StDone);
      fatal_q     <= (state_d == StFail);
    end
  end

  assign dut_reset  = dut_reset_q;
  assign initFlag   = init_q;
  assign wd_poll    = wd_poll_q;
  assign dump_en    = dump_q;
  assign cycle      = cycle_q;
  assign quit_cycle = quit_q;
  assign finish     = finish_q;
  assign fatal      = fatal_q;
  assign fatal_code = code_q;

endmodule

// File: tb/tb_sim_lifecycle_ctrl.sv
// Directed scoreboard bench for sim_lifecycle_ctrl; a second instance runs with a
// 50-cycle global timeout on the same stimulus.
module tb_sim_lifecycle_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        idle = 1'b0;
  logic        wd_valid = 1'b0;
  logic [7:0]  wd_status = 8'd0;
  logic [63:0] dump_start = 64'd0;
  logic [63:0] dump_end = 64'd0;

  logic        dut_reset, initFlag, wd_poll, dump_en, finish, fatal;
  logic [63:0] cycle, quit_cycle;
  logic [1:0]  fatal_code;

  logic        g_dut_reset, g_initFlag, g_wd_poll, g_dump_en, g_finish, g_fatal;
  logic [63:0] g_cycle, g_quit_cycle;
  logic [1:0]  g_fatal_code;

  sim_lifecycle_ctrl u_dut (
    .clock(clock), .reset(reset), .idle(idle), .wd_valid(wd_valid), .wd_status(wd_status),
    .dump_start(dump_start), .dump_end(dump_end), .dut_reset(dut_reset), .initFlag(initFlag),
    .wd_poll(wd_poll), .dump_en(dump_en), .cycle(cycle), .quit_cycle(quit_cycle),
    .finish(finish), .fatal(fatal), .fatal_code(fatal_code)
  );

  sim_lifecycle_ctrl #(.GLOBAL_TIMEOUT(50)) u_gto (
    .clock(clock), .reset(reset), .idle(idle), .wd_valid(wd_valid), .wd_status(wd_status),
    .dump_start(dump_start), .dump_end(dump_end), .dut_reset(g_dut_reset),
    .initFlag(g_initFlag), .wd_poll(g_wd_poll), .dump_en(g_dump_en), .cycle(g_cycle),
    .quit_cycle(g_quit_cycle), .finish(g_finish), .fatal(g_fatal), .fatal_code(g_fatal_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] val);
    expect_v(tag, val);
    observe(obs);
  endtask

  task automatic wait_cycle(input logic [63:0] n, input int budget);
    int k;
    k = 0;
    while (cycle !== n && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    assert (cycle === n) else begin
      n_fail++;
      $error("FAIL wait_cycle: observed cycle %0d expected %0d", cycle, n);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    idle      = 1'b0;
    wd_valid  = 1'b0;
    wd_status = 8'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Normal boot, polling continue, dump window 10..14, global timeout on second instance
    dump_start = 64'd10;
    dump_end   = 64'd15;
    apply_reset();
    wd_valid = 1'b1;
    chk("rst_cycle", cycle, 0);
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_initFlag", initFlag, 1);
    chk("rst_wd_poll", wd_poll, 0);
    chk("rst_dump_en", dump_en, 0);
    chk("rst_quit", quit_cycle, 0);
    chk("rst_code", fatal_code, 0);
    wait_cycle(1, 10);
    chk("c1_initFlag", initFlag, 0);
    chk("c1_dut_reset", dut_reset, 1);
    wait_cycle(4, 10);
    chk("c4_dut_reset", dut_reset, 1);
    chk("c4_wd_poll", wd_poll, 0);
    wait_cycle(5, 10);
    chk("c5_dut_reset", dut_reset, 0);
    chk("c5_wd_poll", wd_poll, 1);
    wait_cycle(9, 10);
    chk("c9_dump_en", dump_en, 0);
    wait_cycle(10, 10);
    chk("c10_dump_en", dump_en, 1);
    wait_cycle(14, 10);
    chk("c14_dump_en", dump_en, 1);
    wait_cycle(15, 10);
    chk("c15_dump_en", dump_en, 0);
    wait_cycle(49, 40);
    chk("g49_fatal", g_fatal, 0);
    wait_cycle(50, 10);
    chk("g50_fatal", g_fatal, 1);
    chk("g50_code", g_fatal_code, 3);
    chk("g50_cycle", g_cycle, 50);
    chk("run_finish", finish, 0);
    chk("run_fatal", fatal, 0);
    tick();
    tick();
    chk("g_cycle_frozen", g_cycle, 50);
    chk("run_wd_poll", wd_poll, 1);

    // Quit while idle: straight to DONE
    dump_start = 64'd10;
    dump_end   = 64'd10;
    apply_reset();
    wd_valid = 1'b1;
    idle     = 1'b1;
    wait_cycle(9, 20);
    chk("eq_c9_dump_en", dump_en, 0);
    wait_cycle(10, 5);
    chk("eq_c10_dump_en", dump_en, 0);
    wait_cycle(20, 20);
    chk("eq_c20_dump_en", dump_en, 0);
    wd_status = 8'hff;
    expect_v("qi_quit", 20);
    expect_v("qi_finish", 1);
    expect_v("qi_cycle", 21);
    tick();
    wd_status = 8'd0;
    wd_valid  = 1'b0;
    observe(quit_cycle);
    observe(finish);
    observe(cycle);
    tick();
    tick();
    tick();
    chk("qi_cycle_frozen", cycle, 21);
    chk("qi_finish_sticky", finish, 1);
    chk("qi_wd_poll", wd_poll, 0);

    // Quit while busy, idle at cycle 30
    dump_start = 64'd10;
    dump_end   = 64'd15;
    apply_reset();
    wd_valid = 1'b1;
    wait_cycle(20, 30);
    wd_status = 8'hff;
    expect_v("qd_quit", 20);
    expect_v("qd_finish", 0);
    expect_v("qd_wd_poll", 0);
    tick();
    wd_status = 8'd0;
    observe(quit_cycle);
    observe(finish);
    observe(wd_poll);
    wait_cycle(30, 20);
    idle = 1'b1;
    expect_v("qd_finish31", 1);
    expect_v("qd_cycle31", 31);
    tick();
    observe(finish);
    observe(cycle);
    chk("qd_fatal", fatal, 0);

    // Quit while busy, never idle: drain timeout
    apply_reset();
    wd_valid = 1'b1;
    wait_cycle(20, 30);
    wd_status = 8'hff;
    tick();
    wd_status = 8'd0;
    wait_cycle(10020, 11000);
    chk("to_c10020_fatal", fatal, 0);
    expect_v("to_fatal", 1);
    expect_v("to_code", 2);
    expect_v("to_cycle", 10021);
    tick();
    observe(fatal);
    observe(fatal_code);
    observe(cycle);
    tick();
    chk("to_finish", finish, 0);
    chk("to_code_held", fatal_code, 2);

    // Watchdog error code
    apply_reset();
    wd_valid = 1'b1;
    wait_cycle(12, 20);
    wd_status = 8'h07;
    expect_v("we_fatal", 1);
    expect_v("we_code", 1);
    expect_v("we_cycle", 13);
    tick();
    wd_status = 8'd0;
    observe(fatal);
    observe(fatal_code);
    observe(cycle);
    tick();
    chk("we_finish", finish, 0);
    chk("we_code_held", fatal_code, 1);

    // Reset mid-DRAIN with dump window open from reset release
    dump_start = 64'd0;
    dump_end   = 64'd0;
    apply_reset();
    wd_valid = 1'b1;
    wait_cycle(1, 5);
    chk("md_c1_dump_en", dump_en, 1);
    wait_cycle(20, 30);
    wd_status = 8'hff;
    tick();
    wd_status = 8'd0;
    wait_cycle(25, 10);
    chk("md_c25_dump_en", dump_en, 1);
    chk("md_c25_wd_poll", wd_poll, 0);
    reset = 1'b1;
    tick();
    chk("md_cycle", cycle, 0);
    chk("md_quit", quit_cycle, 0);
    chk("md_dut_reset", dut_reset, 1);
    chk("md_initFlag", initFlag, 1);
    chk("md_wd_poll", wd_poll, 0);
    chk("md_finish", finish, 0);
    chk("md_fatal", fatal, 0);
    chk("md_code", fatal_code, 0);
    chk("md_dump_en", dump_en, 0);
    reset = 1'b0;
    wait_cycle(6, 10);
    chk("md_rerun_wd_poll", wd_poll, 1);
    chk("md_rerun_finish", finish, 0);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: observed timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
